// File: rtl/fpu_addsub_param.sv
`default_nettype none
// ============================================================================
// Module : fpu_addsub_param
// Multi-cycle parameterised floating-point add/subtract, RNE or truncation.
// Rev    : 1.0
// ============================================================================
module fpu_addsub_param #(
  parameter int EXP_W  = 7,
  parameter int MANT_W = 24
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [EXP_W+MANT_W:0]   a,
  input  logic [EXP_W+MANT_W:0]   b,
  input  logic                    op,
  input  logic                    rm,
  output logic                    busy,
  output logic                    done,
  output logic [EXP_W+MANT_W:0]   data_out,
  output logic [3:0]              status_out
);

  localparam int W    = 1 + EXP_W + MANT_W;
  localparam int SW   = MANT_W + 4;   // hidden + mantissa + guard/round/sticky
  localparam int SUMW = MANT_W + 5;   // SW plus carry
  localparam logic [EXP_W:0] EXP_INF   = {1'b0, {EXP_W{1'b1}}};
  localparam logic [EXP_W:0] SHIFT_CAP = (EXP_W+1)'(MANT_W + 3);
  localparam logic [3:0] ST_INEXACT = 4'b1000;
  localparam logic [3:0] ST_UNDER   = 4'b0100;
  localparam logic [3:0] ST_OVER    = 4'b0010;
  localparam logic [3:0] ST_EXACT   = 4'b0001;

  typedef enum logic [2:0] {
    S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, data_q, data_d;
  logic            op_q, op_d, rm_q, rm_d;
  logic [SW-1:0]   big_q, big_d, small_q, small_d, norm_q, norm_d;
  logic [SUMW-1:0] sum_q, sum_d;
  logic [EXP_W:0]  exp_q, exp_d;
  logic            sign_q, sign_d, sub_q, sub_d, zero_q, zero_d;
  logic            inf_q, inf_d, inf_sign_q, inf_sign_d;
  logic [3:0]      status_q, status_d;

  // Operand unpacking; subtraction folds into B's sign.
  logic             sa, sb, a_inf, b_inf, a_ge_b;
  logic [EXP_W-1:0] ea, eb;
  logic [EXP_W:0]   eff_a, eff_b, big_exp, small_exp, diff, shamt;
  logic [SW-1:0]    ext_a, ext_b, small_ext, aligned;
  logic             lost;

  assign sa     = a_q[W-1];
  assign sb     = b_q[W-1] ^ op_q;
  assign ea     = a_q[W-2:MANT_W];
  assign eb     = b_q[W-2:MANT_W];
  assign a_inf  = &ea;
  assign b_inf  = &eb;
  assign a_ge_b = a_q[W-2:0] >= b_q[W-2:0];
  assign ext_a  = {|ea, a_q[MANT_W-1:0], 3'b000};
  assign ext_b  = {|eb, b_q[MANT_W-1:0], 3'b000};
  assign eff_a  = (ea == '0) ? (EXP_W+1)'(1) : {1'b0, ea};
  assign eff_b  = (eb == '0) ? (EXP_W+1)'(1) : {1'b0, eb};

  assign big_exp   = a_ge_b ? eff_a : eff_b;
  assign small_exp = a_ge_b ? eff_b : eff_a;
  assign small_ext = a_ge_b ? ext_b : ext_a;
  assign diff      = big_exp - small_exp;
  assign shamt     = (diff > SHIFT_CAP) ? SHIFT_CAP : diff;
  assign lost      = |(small_ext & ~({SW{1'b1}} << shamt));
  assign aligned   = (small_ext >> shamt) | SW'(lost);

  // Normalisation: left shift limited so the exponent never drops below 1.
  logic [EXP_W:0] lzc, max_left, shl;
  always_comb begin
    lzc = (EXP_W+1)'(SW);
    for (int i = 0; i < SW; i++) begin
      if (sum_q[i]) lzc = (EXP_W+1)'(SW - 1 - i);
    end
  end
  assign max_left = exp_q - (EXP_W+1)'(1);
  assign shl      = (lzc < max_left) ? lzc : max_left;

  // Rounding of the normalised significand.
  logic [MANT_W:0]   mant_n;
  logic [MANT_W+1:0] rounded;
  logic [MANT_W-1:0] frac;
  logic [EXP_W:0]    exp_r;
  logic [EXP_W-1:0]  field;
  logic              inexact, round_up, rcarry, hidden, ovf;

  assign mant_n   = norm_q[SW-1:3];
  assign inexact  = |norm_q[2:0];
  assign round_up = ~rm_q & norm_q[2] & (norm_q[1] | norm_q[0] | mant_n[0]);
  assign rounded  = {1'b0, mant_n} + (MANT_W+2)'(round_up);
  assign rcarry   = rounded[MANT_W+1];
  assign hidden   = rcarry | rounded[MANT_W];
  assign frac     = rcarry ? '0 : rounded[MANT_W-1:0];
  assign exp_r    = exp_q + (EXP_W+1)'(rcarry);
  assign ovf      = hidden & (exp_r >= EXP_INF);
  assign field    = hidden ? exp_r[EXP_W-1:0] : '0;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    rm_d       = rm_q;
    big_d      = big_q;
    small_d    = small_q;
    sum_d      = sum_q;
    norm_d     = norm_q;
    exp_d      = exp_q;
    sign_d     = sign_q;
    sub_d      = sub_q;
    zero_d     = zero_q;
    inf_d      = inf_q;
    inf_sign_d = inf_sign_q;
    data_d     = data_q;
    status_d   = status_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          rm_d    = rm;
          state_d = S_ALIGN;
        end
      end
      S_ALIGN: begin
        big_d   = a_ge_b ? ext_a : ext_b;
        small_d = aligned;
        exp_d   = big_exp;
        sign_d  = a_ge_b ? sa : sb;
        sub_d   = sa ^ sb;
        inf_d   = a_inf | b_inf;
        // inf - inf resolves to +inf
        if (a_inf && b_inf) inf_sign_d = (sa == sb) ? sa : 1'b0;
        else                inf_sign_d = a_inf ? sa : sb;
        state_d = S_ADD;
      end
      S_ADD: begin
        sum_d   = sub_q ? ({1'b0, big_q} - {1'b0, small_q})
                        : ({1'b0, big_q} + {1'b0, small_q});
        zero_d  = (sub_q ? (big_q == small_q) : 1'b0) | ((big_q | small_q) == '0);
        state_d = S_NORM;
      end
      S_NORM: begin
        if (sum_q[SUMW-1]) begin
          norm_d = sum_q[SUMW-1:1] | SW'(sum_q[0]);
          exp_d  = exp_q + (EXP_W+1)'(1);
        end else begin
          norm_d = sum_q[SW-1:0] << shl;
          exp_d  = exp_q - shl;
        end
        state_d = S_ROUND;
      end
      S_ROUND: begin
        if (inf_q) begin
          data_d   = {inf_sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
          status_d = ST_OVER;
        end else if (zero_q) begin
          data_d   = '0;
          status_d = ST_EXACT;
        end else if (ovf) begin
          data_d   = {sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
          status_d = ST_OVER;
        end else begin
          data_d = {sign_q, field, frac};
          if (field == '0)  status_d = ST_UNDER;
          else if (inexact) status_d = ST_INEXACT;
          else              status_d = ST_EXACT;
        end
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= 1'b0;
      rm_q       <= 1'b0;
      big_q      <= '0;
      small_q    <= '0;
      sum_q      <= '0;
      norm_q     <= '0;
      exp_q      <= (EXP_W+1)'(1);
      sign_q     <= 1'b0;
      sub_q      <= 1'b0;
      zero_q     <= 1'b0;
      inf_q      <= 1'b0;
      inf_sign_q <= 1'b0;
      data_q     <= '0;
      status_q   <= ST_EXACT;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      rm_q       <= rm_d;
      big_q      <= big_d;
      small_q    <= small_d;
      sum_q      <= sum_d;
      norm_q     <= norm_d;
      exp_q      <= exp_d;
      sign_q     <= sign_d;
      sub_q      <= sub_d;
      zero_q     <= zero_d;
      inf_q      <= inf_d;
      inf_sign_q <= inf_sign_d;
      data_q     <= data_d;
      status_q   <= status_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign data_out   = data_q;
  assign status_out = status_q;

endmodule
`default_nettype wire

// File: tb/tb_fpu_addsub_param.sv
`default_nettype none
// ============================================================================
// Module : tb_fpu_addsub_param
// Directed bench for fpu_addsub_param at default and IEEE-single parameters.
// Rev    : 1.0
// ============================================================================
module tb_fpu_addsub_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, op, rm;
  logic [31:0] a, b, a8, b8;
  logic        busy, done, busy8, done8;
  logic [31:0] data_out, data_out8;
  logic [3:0]  status_out, status_out8;
  int          checks = 0;
  int          errors = 0;
  int          ndone;
  logic [31:0] held;

  always #5 clk = ~clk;

  fpu_addsub_param dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .op(op), .rm(rm),
    .busy(busy), .done(done), .data_out(data_out), .status_out(status_out)
  );

  fpu_addsub_param #(.EXP_W(8), .MANT_W(23)) dut8 (
    .clk(clk), .reset(reset), .start(start), .a(a8), .b(b8), .op(op), .rm(rm),
    .busy(busy8), .done(done8), .data_out(data_out8), .status_out(status_out8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Leaves the caller at the negedge of the DONE cycle (or after the bound expires).
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tbv, input logic top,
                        input logic trm, input logic [31:0] ta8, input logic [31:0] tb8);
    int lat;
    @(negedge clk);
    a = ta; b = tbv; op = top; rm = trm; a8 = ta8; b8 = tb8; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(negedge clk);
      if (done === 1'b1) lat = k;
    end
    check("latency", lat, 5);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; op = 1'b0; rm = 1'b0;
    a = '0; b = '0; a8 = '0; b8 = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_data", data_out, 32'h0);
    check("rst_status", status_out, 4'b0001);
    check("rst_busy8", busy8, 0);
    reset = 1'b1;

    // 1.0 + 1.0
    run_op(32'h3F000000, 32'h3F000000, 1'b0, 1'b0, 32'h3F800000, 32'h3F800000);
    check("add_data", data_out, 32'h40000000);
    check("add_status", status_out, 4'b0001);
    check("add_done8", done8, 1);
    check("add_data8", data_out8, 32'h40000000);
    check("add_status8", status_out8, 4'b0001);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("idle_busy", busy, 0);
    check("held_data", data_out, 32'h40000000);

    // 1.0 - 1.0
    run_op(32'h3F000000, 32'h3F000000, 1'b1, 1'b0, 32'h0, 32'h0);
    check("sub_zero_data", data_out, 32'h00000000);
    check("sub_zero_status", status_out, 4'b0001);

    // Tie and above-half rounding, both modes
    run_op(32'h3F000000, 32'h26000000, 1'b0, 1'b0, 32'h3F800000, 32'h33800000);
    check("tie_rne_data", data_out, 32'h3F000000);
    check("tie_rne_status", status_out, 4'b1000);
    check("tie_rne_data8", data_out8, 32'h3F800000);
    check("tie_rne_status8", status_out8, 4'b1000);
    run_op(32'h3F000000, 32'h26800000, 1'b0, 1'b0, 32'h3F800000, 32'h33C00000);
    check("up_rne_data", data_out, 32'h3F000001);
    check("up_rne_status", status_out, 4'b1000);
    check("up_rne_data8", data_out8, 32'h3F800001);
    check("up_rne_status8", status_out8, 4'b1000);
    run_op(32'h3F000000, 32'h26800000, 1'b0, 1'b1, 32'h3F800000, 32'h33C00000);
    check("trunc_data", data_out, 32'h3F000000);
    check("trunc_status", status_out, 4'b1000);
    check("trunc_data8", data_out8, 32'h3F800000);
    check("trunc_status8", status_out8, 4'b1000);

    // Overflow and subnormal underflow
    run_op(32'h7EFFFFFF, 32'h7EFFFFFF, 1'b0, 1'b0, 32'h0, 32'h0);
    check("ovf_data", data_out, 32'h7F000000);
    check("ovf_status", status_out, 4'b0010);
    run_op(32'h01800000, 32'h01000000, 1'b1, 1'b0, 32'h0, 32'h0);
    check("unf_data", data_out, 32'h00800000);
    check("unf_status", status_out, 4'b0100);

    // Differing exponents with a negative result: 1.0 - 2.0 = -1.0
    run_op(32'h3F000000, 32'h40000000, 1'b1, 1'b0, 32'h0, 32'h0);
    check("neg_data", data_out, 32'hBF000000);
    check("neg_status", status_out, 4'b0001);

    // Infinite operands
    run_op(32'h7F000000, 32'h3F000000, 1'b0, 1'b0, 32'h0, 32'h0);
    check("inf_a_data", data_out, 32'h7F000000);
    check("inf_a_status", status_out, 4'b0010);
    run_op(32'h3F000000, 32'h7F000000, 1'b1, 1'b0, 32'h0, 32'h0);
    check("inf_negb_data", data_out, 32'hFF000000);
    check("inf_negb_status", status_out, 4'b0010);
    run_op(32'h7F000000, 32'h7F000000, 1'b1, 1'b0, 32'h0, 32'h0);
    check("inf_minus_inf", data_out, 32'h7F000000);
    check("inf_minus_inf_st", status_out, 4'b0010);

    // start held high with operands changing while busy
    @(negedge clk);
    a = 32'h3F000000; b = 32'h3F000000; op = 1'b0; rm = 1'b0; start = 1'b1;
    ndone = 0; held = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      a = $urandom; b = $urandom; op = 1'($urandom); rm = 1'($urandom);
      if (done === 1'b1) begin
        ndone++;
        held = data_out;
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("hold_start_dones", ndone, 1);
    check("hold_start_data", held, 32'h40000000);

    // Reset asserted while the operation is in ADD
    @(negedge clk);
    a = 32'h3F000000; b = 32'h26800000; op = 1'b0; rm = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("add_state_busy", busy, 1);
    reset = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_data", data_out, 32'h0);
    check("abort_status", status_out, 4'b0001);
    ndone = 0;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    reset = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    check("abort_no_done", ndone, 0);
    run_op(32'h3F000000, 32'h3F000000, 1'b0, 1'b0, 32'h3F800000, 32'h3F800000);
    check("post_rst_data", data_out, 32'h40000000);
    check("post_rst_status", status_out, 4'b0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
